// File: rtl/mem_access_sequencer.sv
// MEM-stage access sequencer: drives a single-outstanding req/gnt/rvalid data bus
// for loads, byte-strobed stores and two-beat vector stores. Optional watchdog: MEM_TIMEOUT_EN.
module mem_access_sequencer #(
  parameter int unsigned VEC_STRIDE     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemToRegM,
  input  logic [3:0]  MemWriteM,
  input  logic        MemWriteVecM,
  input  logic [31:0] AluOutM,
  input  logic [31:0] StoreDataM,
  input  logic [63:0] VecRegWriteData,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata,
  output logic [31:0] LoadDataM,
  output logic        stall_mem,
  output logic        flush_wb,
  output logic        busy,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, REQ0, RSP0, REQ1, RSP1, DONE} state_t;
  typedef enum logic [1:0] {K_LOAD, K_STORE, K_VEC} kind_t;

  state_t state;
  kind_t  kind;
  logic   acc;

  assign acc = MemToRegM | (|MemWriteM) | MemWriteVecM;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] wd_cnt;
  logic          timeout;

  // Fires on the cycle the count would reach the limit, so DONE follows exactly
  // TIMEOUT_CYCLES response-wait cycles.
  assign timeout = (wd_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  assign err = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge value of every other register regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      kind      <= K_LOAD;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_wstrb <= '0;
      LoadDataM <= '0;
`ifdef MEM_TIMEOUT_EN
      err       <= 1'b0;
      wd_cnt    <= '0;
`endif
    end else begin
`ifdef MEM_TIMEOUT_EN
      err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (acc) begin
            bus_req  <= 1'b1;
            bus_addr <= AluOutM;
            state    <= REQ0;
            if (MemWriteVecM) begin
              kind      <= K_VEC;
              bus_we    <= 1'b1;
              bus_wdata <= VecRegWriteData[31:0];
              bus_wstrb <= 4'hF;
            end else if (|MemWriteM) begin
              kind      <= K_STORE;
              bus_we    <= 1'b1;
              bus_wdata <= StoreDataM;
              bus_wstrb <= MemWriteM;
            end else begin
              kind      <= K_LOAD;
              bus_we    <= 1'b0;
              bus_wstrb <= 4'h0;
            end
          end
        end

        REQ0, REQ1: begin
          if (bus_gnt) begin
            bus_req <= 1'b0;
            state   <= (state == REQ0) ? RSP0 : RSP1;
`ifdef MEM_TIMEOUT_EN
            wd_cnt  <= '0;
`endif
          end
        end

        RSP0, RSP1: begin
          if (bus_rvalid) begin
            if (kind == K_LOAD) LoadDataM <= bus_rdata;
            if (state == RSP0 && kind == K_VEC) begin
              bus_addr  <= AluOutM + 32'(VEC_STRIDE);
              bus_wdata <= VecRegWriteData[63:32];
              bus_req   <= 1'b1;
              state     <= REQ1;
            end else begin
              state <= DONE;
            end
          end
`ifdef MEM_TIMEOUT_EN
          else if (timeout) begin
            state <= DONE;
            err   <= 1'b1;
            if (kind == K_LOAD) LoadDataM <= '0;
          end else begin
            wd_cnt <= wd_cnt + 1'b1;
          end
`endif
        end

        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Gated by rst_n so a reset drops the stall at once even while EX/MEM still holds an access.
  assign stall_mem = rst_n & (((state == IDLE) && acc) ||
                              (state inside {REQ0, RSP0, REQ1, RSP1}));
  assign flush_wb  = stall_mem;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Self-checking bench for mem_access_sequencer: directed cases plus randomized
// accesses checked against a transaction-level beat model.
module tb_mem_access_sequencer;

  localparam logic [31:0] STRIDE = 32'd4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemToRegM;
  logic [3:0]  MemWriteM;
  logic        MemWriteVecM;
  logic [31:0] AluOutM;
  logic [31:0] StoreDataM;
  logic [63:0] VecRegWriteData;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_gnt, bus_rvalid;
  logic [31:0] bus_rdata;
  logic [31:0] LoadDataM;
  logic        stall_mem, flush_wb, busy, err;

  int compared   = 0;
  int mismatched = 0;
  logic [31:0] exp_load;

  always #5 clk = ~clk;

  mem_access_sequencer #(.VEC_STRIDE(4), .TIMEOUT_CYCLES(255)) dut (
    .clk(clk), .rst_n(rst_n),
    .MemToRegM(MemToRegM), .MemWriteM(MemWriteM), .MemWriteVecM(MemWriteVecM),
    .AluOutM(AluOutM), .StoreDataM(StoreDataM), .VecRegWriteData(VecRegWriteData),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
    .bus_wstrb(bus_wstrb), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata), .LoadDataM(LoadDataM), .stall_mem(stall_mem),
    .flush_wb(flush_wb), .busy(busy), .err(err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    MemToRegM = 1'b0; MemWriteM = 4'h0; MemWriteVecM = 1'b0;
    AluOutM = '0; StoreDataM = '0; VecRegWriteData = '0;
    bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
  endtask

  // Called just after a rising edge with the DUT idle. gwait/rwait < 0 means random waits.
  task automatic run_access(input logic ld, input logic [3:0] strb, input logic vec,
                            input logic [31:0] addr, input logic [31:0] sdata,
                            input logic [63:0] vdata, input int gwait, input int rwait,
                            input bit fixed_rd, input logic [31:0] rd_val);
    logic [31:0] b_addr[2];
    logic [31:0] b_wdata[2];
    logic [3:0]  b_strb;
    logic        b_we;
    int nb, beat, wc, stalls;
    bit in_rsp, fin;

    // Expected beats, from the priority rule: vector > scalar store > load.
    b_addr[0] = addr; b_addr[1] = addr + STRIDE;
    b_wdata[0] = '0;  b_wdata[1] = '0;
    if (vec) begin
      nb = 2; b_wdata[0] = vdata[31:0]; b_wdata[1] = vdata[63:32]; b_strb = 4'hF; b_we = 1'b1;
    end else if (strb != 4'h0) begin
      nb = 1; b_wdata[0] = sdata; b_strb = strb; b_we = 1'b1;
    end else begin
      nb = 1; b_strb = 4'h0; b_we = 1'b0;
    end

    MemToRegM = ld; MemWriteM = strb; MemWriteVecM = vec;
    AluOutM = addr; StoreDataM = sdata; VecRegWriteData = vdata;
    bus_gnt = 1'b0; bus_rvalid = 1'b0;

    @(negedge clk);
    check("idle_stall", stall_mem, 1);
    check("idle_req", bus_req, 0);
    check("idle_busy", busy, 0);
    stalls = int'(stall_mem);

    beat = 0; wc = 0; in_rsp = 1'b0; fin = 1'b0;
    for (int cyc = 0; cyc < 300 && !fin; cyc++) begin
      @(posedge clk); #1;
      if (!in_rsp) begin
        bus_gnt    = (gwait < 0) ? ($urandom_range(0, 2) == 0) : (wc >= gwait);
        bus_rvalid = 1'($urandom_range(0, 1));
      end else begin
        bus_gnt    = 1'($urandom_range(0, 1));
        bus_rvalid = (rwait < 0) ? ($urandom_range(0, 2) == 0) : (wc >= rwait);
      end
      bus_rdata = fixed_rd ? rd_val : $urandom;
      @(negedge clk);
      stalls += int'(stall_mem);
      check("busy", busy, 1);
      check("stall", stall_mem, 1);
      check("flush", flush_wb, 1);
      if (!in_rsp) begin
        check("req", bus_req, 1);
        check("addr", bus_addr, b_addr[beat]);
        check("we", bus_we, b_we);
        check("wstrb", bus_wstrb, b_strb);
        if (b_we) check("wdata", bus_wdata, b_wdata[beat]);
        if (bus_gnt) begin in_rsp = 1'b1; wc = 0; end else wc++;
      end else begin
        check("req_low", bus_req, 0);
        if (bus_rvalid) begin
          if (!b_we) exp_load = bus_rdata;
          beat++; wc = 0; in_rsp = 1'b0;
          if (beat == nb) fin = 1'b1;
        end else wc++;
      end
    end
    if (!fin) check("access_timeout", 0, 1);

    // DONE cycle, with a stray rvalid that must be ignored
    @(posedge clk); #1;
    bus_gnt = 1'b0; bus_rvalid = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
    @(negedge clk);
    check("done_busy", busy, 1);
    check("done_stall", stall_mem, 0);
    check("done_flush", flush_wb, 0);
    check("done_req", bus_req, 0);
    check("done_load", LoadDataM, exp_load);
    if (gwait >= 0 && rwait >= 0)
      check("stall_cycles", stalls, 1 + nb * (gwait + rwait + 2));

    @(posedge clk); #1;
    clear_inputs();
    @(negedge clk);
    check("back_idle", busy, 0);
    check("idle_hold_load", LoadDataM, exp_load);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [3:0]  r_strb;
    logic        r_vec, r_ld;
    clear_inputs();
    exp_load = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", bus_req, 0);
    check("rst_we", bus_we, 0);
    check("rst_addr", bus_addr, 0);
    check("rst_wdata", bus_wdata, 0);
    check("rst_wstrb", bus_wstrb, 0);
    check("rst_load", LoadDataM, 0);
    check("rst_err", err, 0);
    check("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    run_access(1'b1, 4'h0, 1'b0, 32'h100, 32'h0, 64'h0, 1, 1, 1'b1, 32'hCAFEF00D);
    check("load_value", LoadDataM, 32'hCAFEF00D);
    run_access(1'b0, 4'b0010, 1'b0, 32'h204, 32'h0000AB00, 64'h0, 0, 0, 1'b0, 32'h0);
    run_access(1'b0, 4'h0, 1'b1, 32'hFFFFFFFC, 32'h0, 64'h11112222_33334444, 0, 1, 1'b0, 32'h0);
    run_access(1'b0, 4'b1100, 1'b0, 32'h300, 32'hDEADBEEF, 64'h0, 5, 0, 1'b0, 32'h0);
    run_access(1'b1, 4'hF, 1'b1, 32'h400, 32'h12345678, 64'hAAAA5555_0F0F1234, 0, 0, 1'b0, 32'h0);
    run_access(1'b1, 4'b0001, 1'b0, 32'h500, 32'h000000EE, 64'h0, 0, 2, 1'b0, 32'h0);

    // Randomized accesses, including mixed kind bits resolved by priority
    for (int n = 0; n < 40; n++) begin
      r_strb = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'h0;
      r_vec  = ($urandom_range(0, 3) == 0);
      r_ld   = 1'($urandom_range(0, 1));
      if (!r_ld && r_strb == 4'h0 && !r_vec) r_ld = 1'b1;
      run_access(r_ld, r_strb, r_vec, $urandom, $urandom, {$urandom, $urandom},
                 -1, -1, 1'b0, 32'h0);
    end

    // Reset while in RSP1 of a vector store
    MemWriteVecM = 1'b1; AluOutM = 32'h800; VecRegWriteData = 64'h99998888_77776666;
    bus_gnt = 1'b1; bus_rvalid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus_gnt = 1'b0; bus_rvalid = 1'b1;
    @(posedge clk); #1;
    bus_gnt = 1'b1; bus_rvalid = 1'b0;
    @(posedge clk); #1;
    bus_gnt = 1'b0;
    check("rsp1_busy", busy, 1);
    check("rsp1_addr", bus_addr, 32'h804);
    #2 rst_n = 1'b0;
    #1;
    check("arst_req", bus_req, 0);
    check("arst_stall", stall_mem, 0);
    check("arst_busy", busy, 0);
    check("arst_addr", bus_addr, 0);
    check("arst_load", LoadDataM, 0);
    @(posedge clk); #1;
    clear_inputs();
    rst_n = 1'b1;
    bus_rvalid = 1'b1; bus_rdata = 32'h5A5A5A5A;
    @(negedge clk);
    check("late_rvalid_busy", busy, 0);
    check("late_rvalid_load", LoadDataM, 0);
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    @(negedge clk);
    check("late_rvalid_req", bus_req, 0);
    check("late_rvalid_stall", stall_mem, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
